// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_parser
// Description : Assembles fixed-length command frames from a UART byte stream.
//               Frame = SYNC, CMD, ARG[0..ARG_BYTES-1] (MSB first), CHK, where
//               CHK is the XOR of CMD and every ARG byte. Good frames are held
//               on a valid/ready output; checksum failures, inter-byte
//               timeouts and output overruns raise one-cycle error pulses.
// Ports       : clk, reset       - clock, synchronous active-high reset
//               rx_byte/rx_valid - received byte and its one-cycle strobe
//               cmd/arg          - held frame (first ARG byte in arg MSBs)
//               cmd_valid        - held frame available
//               cmd_ready        - consumer takes the frame while cmd_valid=1
//               busy             - parser is inside a frame
//               chk_err          - pulse: checksum mismatch, frame dropped
//               timeout_err      - pulse: inter-byte timeout, frame aborted
//               overrun_err      - pulse: good frame dropped, output occupied
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_parser #(
  parameter int         CLK_FREQ       = 100_000_000,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0] SYNC_BYTE      = 8'hAA,
  parameter int         ARG_BYTES      = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_byte,
  input  logic                   rx_valid,
  output logic [7:0]             cmd,
  output logic [8*ARG_BYTES-1:0] arg,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic                   busy,
  output logic                   chk_err,
  output logic                   timeout_err,
  output logic                   overrun_err
);

  localparam int                CNT_W       = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  c_tmo_last  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]        c_idx_last  = 3'(ARG_BYTES - 1);

  generate
    if (ARG_BYTES < 1 || ARG_BYTES > 4 || TIMEOUT_CYCLES < 1 || CLK_FREQ <= 0) begin : g_bad_params
      $error("uart_cmd_parser: illegal parameter value");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_ARG  = 2'd2,
    S_CHK  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [7:0]              r_cmd_sh;
  logic [8*ARG_BYTES-1:0]  r_arg_sh;
  logic [8*ARG_BYTES-1:0]  w_arg_shift;
  logic [7:0]              r_chk_acc;
  logic [2:0]              r_idx;
  logic [CNT_W-1:0]        r_tmo_cnt;
  logic                    w_good;
  logic                    w_bad;
  logic                    w_timeout;

  // Next shadow-arg value: new byte enters at the LSB end so the first
  // received byte ends up in the MSBs.
  generate
    if (ARG_BYTES == 1) begin : g_arg_one
      assign w_arg_shift = rx_byte;
    end else begin : g_arg_multi
      assign w_arg_shift = {r_arg_sh[8*ARG_BYTES-9:0], rx_byte};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_good       = 1'b0;
    w_bad        = 1'b0;
    w_timeout    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (rx_valid && (rx_byte == SYNC_BYTE)) begin
          w_state_next = S_CMD;
        end
      end
      S_CMD: begin
        if (rx_valid) begin
          w_state_next = S_ARG;
        end
      end
      S_ARG: begin
        if (rx_valid && (r_idx == c_idx_last)) begin
          w_state_next = S_CHK;
        end
      end
      S_CHK: begin
        if (rx_valid) begin
          w_state_next = S_IDLE;
          if (rx_byte == r_chk_acc) begin
            w_good = 1'b1;
          end else begin
            w_bad = 1'b1;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    // A byte arriving in the expiry cycle wins, so only idle cycles expire.
    if ((r_state != S_IDLE) && !rx_valid && (r_tmo_cnt == c_tmo_last)) begin
      w_state_next = S_IDLE;
      w_timeout    = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Frame assembly, timeout counter, output holding register, error pulses
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd_sh    <= '0;
      r_arg_sh    <= '0;
      r_chk_acc   <= '0;
      r_idx       <= '0;
      r_tmo_cnt   <= '0;
      cmd         <= '0;
      arg         <= '0;
      cmd_valid   <= 1'b0;
      chk_err     <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      chk_err     <= w_bad;
      timeout_err <= w_timeout;
      overrun_err <= w_good && cmd_valid && !cmd_ready;

      if ((r_state == S_IDLE) || rx_valid) begin
        r_tmo_cnt <= '0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end

      if (rx_valid) begin
        case (r_state)
          S_IDLE: begin
            r_chk_acc <= '0;
          end
          S_CMD: begin
            r_cmd_sh  <= rx_byte;
            r_chk_acc <= rx_byte;
            r_idx     <= '0;
          end
          S_ARG: begin
            r_arg_sh  <= w_arg_shift;
            r_chk_acc <= r_chk_acc ^ rx_byte;
            r_idx     <= r_idx + 3'd1;
          end
          default: ;
        endcase
      end

      // A completing frame may replace the held one only if the held one is
      // being taken in this same cycle; that keeps cmd_valid high with no gap.
      if (w_good && (!cmd_valid || cmd_ready)) begin
        cmd       <= r_cmd_sh;
        arg       <= r_arg_sh;
        cmd_valid <= 1'b1;
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end
    end
  end

  assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Consumes the byte stream from the UART receive stage and assembles fixed-length command frames.
- Frame format: SYNC, CMD, ARG bytes (MSB first), CHK.
- Validated frames go to the control logic on a valid/ready handshake.
- Checksum failures, inter-byte timeouts and overruns are flagged as single-cycle error pulses.

Parameters:
- CLK_FREQ, 100_000_000: clock frequency in Hz. Informational; used to derive the default timeout.
- TIMEOUT_CYCLES, 1_000_000: maximum idle clocks allowed between bytes inside a frame (10 ms at the default clock).
- SYNC_BYTE, 8'hAA: frame start marker.
- ARG_BYTES, 2: number of argument bytes per frame. Legal range 1..4.

Ports:
- clk  input  1  system clock, 100 MHz
- reset  input  1  reset, synchronous, active-high
- rx_byte  input  8  received byte; valid only when rx_valid=1
- rx_valid  input  1  single-cycle strobe, one per received byte
- cmd  output  8  command byte of the held frame
- arg  output  8*ARG_BYTES  argument of the held frame, first-received byte in the MSBs
- cmd_valid  output  1  held frame available
- cmd_ready  input  1  consumer accepts the held frame when cmd_valid=1
- busy  output  1  high whenever state != IDLE
- chk_err  output  1  one-cycle pulse: checksum mismatch, frame dropped
- timeout_err  output  1  one-cycle pulse: inter-byte timeout, frame aborted
- overrun_err  output  1  one-cycle pulse: valid frame dropped because the output was still occupied

Behaviour:
- Reset: state=IDLE; cmd, arg, cmd_valid, all error pulses, checksum accumulator, byte index and timeout counter all 0. Reset mid-frame discards the partial frame and any held output.
- States and transitions (moves happen only on cycles where rx_valid=1, except timeout):
  - IDLE: rx_byte==SYNC_BYTE -> CMD. Any other byte is ignored silently, with no error.
  - CMD: latch the byte into the shadow cmd register; chk_acc = byte; -> ARG with idx=0.
  - ARG: shift the byte into the shadow arg register; chk_acc ^= byte; idx+1. When idx==ARG_BYTES-1 -> CHK.
  - CHK: rx_byte==chk_acc -> frame good; otherwise chk_err pulses next cycle. -> IDLE in both cases.
- SYNC_BYTE received mid-frame is treated as ordinary data; there is no resynchronisation.
- Checksum: 8-bit XOR of CMD and all ARG bytes, accumulator initialised to 0 at each frame start.
- Output latency: cmd_valid rises on the clock edge after the CHK byte's rx_valid cycle, with cmd/arg updated on the same edge.
- Output hold:
  - cmd, arg and cmd_valid stay stable until a cycle with cmd_valid&&cmd_ready; cmd_valid clears on the following edge.
  - cmd_ready is ignored while cmd_valid=0.
- Good frame completes while cmd_valid=1:
  - If cmd_ready=1 in that same cycle: the new frame loads and cmd_valid stays 1, so no bubble and no error.
  - Otherwise: the new frame is dropped, the held frame is kept, and overrun_err pulses.
- Timeout:
  - Counter clears on every rx_valid and whenever state==IDLE.
  - In CMD/ARG/CHK it increments each clock without rx_valid.
  - On reaching TIMEOUT_CYCLES-1: -> IDLE, partial frame discarded, timeout_err pulses on the next edge.
  - rx_valid in the same cycle as expiry takes priority: the byte is processed and the counter clears.
  - Counter width is $clog2(TIMEOUT_CYCLES)+1, with no wrap before expiry.
- Error pulses last exactly one cycle, never affect cmd_valid or the held frame, and may coincide with each other only across different cycles.
- Back-to-back bytes on consecutive cycles must be accepted; the block adds no throughput limit.

Test Plan:
- Bytes AA,12,34,56,70 with cmd_ready=1 -> one cycle after the 0x70 strobe: cmd_valid=1, cmd=0x12, arg=0x3456; cmd_valid clears the following cycle. No errors.
- Bytes 00,FF,55 then AA,12,34,56,70 -> leading bytes ignored with no errors; exactly one frame delivered: cmd=0x12, arg=0x3456.
- Bytes AA,12,34,56,71 -> chk_err pulses for 1 cycle; cmd_valid stays 0; next frame AA,01,00,02,03 delivered with cmd=0x01, arg=0x0002.
- Bytes AA,12 then no bytes for TIMEOUT_CYCLES (use TIMEOUT_CYCLES=100 in bench) -> timeout_err pulses once, busy falls; a following good frame is delivered correctly.
- cmd_ready=0: two good frames 0x12/0x3456 then AA,20,00,01,21 -> overrun_err on the second frame; output holds cmd=0x12. Raise cmd_ready -> handoff, then cmd_valid=0.
- Reset asserted after AA,12,34 -> busy=0 and all outputs 0; then AA,12,34,56,70 -> a single correct frame.
